// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: window select, register indices, TCON bits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h4000_0000;
  // Address[31:5] must equal this for the 32-byte window to be selected.
  localparam logic [26:0] MMIO_SEL  = MMIO_BASE[31:5];

  localparam logic [2:0] IDX_TH      = 3'd0;
  localparam logic [2:0] IDX_TL      = 3'd1;
  localparam logic [2:0] IDX_TCON    = 3'd2;
  localparam logic [2:0] IDX_LED     = 3'd3;
  localparam logic [2:0] IDX_TXD     = 3'd4;
  localparam logic [2:0] IDX_STAT    = 3'd5;
  localparam logic [2:0] IDX_SYSTICK = 3'd6;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_OVF = 2;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
// Latency: tx follows the state by one cycle; a byte occupies 10*CLKS_PER_BIT cycles.
// Backpressure: start is honoured only in IDLE; busy stays high for the whole frame.
module uart_tx_serializer
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  ser_state_e        state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shreg_q;
  logic              tx_q;

  // Frame state machine; the line level is registered from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_q <= (state_q == SER_START) ? 1'b0 :
              (state_q == SER_DATA)  ? shreg_q[0] : 1'b1;
      case (state_q)
        SER_IDLE: begin
          if (start) begin
            state_q <= SER_START;
            shreg_q <= data;
            baud_q  <= '0;
          end
        end
        SER_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= SER_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        SER_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_q == 3'd7) state_q <= SER_STOP;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        SER_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= SER_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign busy = (state_q != SER_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/mmio_peripheral_responder.sv
// MMIO window at 0x4000_0000: timer+irq, LED register, systick, UART TX with byte FIFO.
// Latency: writes commit at the request edge; Read_data is registered at that edge (pre-edge state).
// Backpressure: none on the bus; a TXD push into a full FIFO is dropped and flagged in STAT.
module mmio_peripheral_responder
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic [7:0]  leds,
  output logic        irq,
  output logic        uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      th_q, th_d, tl_q, tl_d, tick_q, tick_d, rdata_q, rdata_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [7:0]       leds_q, leds_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];

  logic        sel, wr_en, rd_en, ovf;
  logic [2:0]  idx;
  logic        fifo_full, fifo_empty, push, push_ok, pop, ser_busy;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign sel         = (Address[31:5] == MMIO_SEL);
  assign idx         = Address[4:2];
  assign wr_en       = MemWrite && sel;
  assign rd_en       = MemRead && sel;
  assign unused_addr = ^Address[1:0];

  // Full is judged on pre-edge occupancy, so a simultaneous pop cannot make room for a push.
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = wr_en && (idx == IDX_TXD);
  assign push_ok    = push && !fifo_full;
  assign pop        = !ser_busy && !fifo_empty;

  assign ovf = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // Read-back mux over pre-edge register state; unselected or unmapped reads give zero.
  always_comb begin
    rd_mux = '0;
    if (sel) begin
      case (idx)
        IDX_TH:      rd_mux = th_q;
        IDX_TL:      rd_mux = tl_q;
        IDX_TCON:    rd_mux = {29'b0, tcon_q};
        IDX_LED:     rd_mux = {24'b0, leds_q};
        IDX_STAT:    rd_mux = {25'b0, drop_q, 3'(cnt_q), ser_busy, fifo_empty, fifo_full};
        IDX_SYSTICK: rd_mux = tick_q;
        default:     rd_mux = '0;
      endcase
    end
  end

  // Next-state for timer, LED, FIFO bookkeeping, drop flag, systick and read data.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    leds_d = leds_q;
    if (tcon_q[TCON_EN]) tl_d = ovf ? th_q : tl_q + 32'd1;
    tcon_d[TCON_OVF] = tcon_q[TCON_OVF] | ovf;
    if (wr_en) begin
      case (idx)
        IDX_TH:   th_d   = Write_data;
        IDX_TL:   tl_d   = Write_data;
        // Software can clear the status, but an overflow on this same edge still lands.
        IDX_TCON: tcon_d = {Write_data[TCON_OVF] | ovf, Write_data[TCON_IE], Write_data[TCON_EN]};
        IDX_LED:  leds_d = Write_data[7:0];
        default:  ;
      endcase
    end

    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // A drop on the same edge as a STAT read must survive the read-clear.
    drop_d = drop_q;
    if (rd_en && (idx == IDX_STAT)) drop_d = 1'b0;
    if (push && fifo_full)          drop_d = 1'b1;

    tick_d  = tick_q + 32'd1;
    rdata_d = MemRead ? rd_mux : rdata_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q     <= '0;
      tl_q     <= '0;
      tcon_q   <= '0;
      leds_q   <= '0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tick_q   <= '0;
      rdata_q  <= '0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      tcon_q   <= tcon_d;
      leds_q   <= leds_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tick_q   <= tick_d;
      rdata_q  <= rdata_d;
    end
  end

  // FIFO byte storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= Write_data[7:0];
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .rst_n(reset),
    .data (fifo_mem_q[rd_ptr_q]),
    .start(pop),
    .busy (ser_busy),
    .tx   (uart_tx)
  );

  assign Read_data = rdata_q;
  assign leds      = leds_q;
  assign irq       = tcon_q[TCON_IE] & tcon_q[TCON_OVF];

endmodule
